// File: rtl/serializador_der_izq_pkg.sv
// Shared definitions for the right-to-left serializer.
//   estado_t  : FSM state encoding (IDLE/DESPLAZA/CAPTURA)
//   ancho_cnt : bit-pair counter width for a given N (never below 1)
package serializador_der_izq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DESPLAZA = 2'd1,
    CAPTURA  = 2'd2
  } estado_t;

  function automatic int ancho_cnt(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serializador_der_izq_contador_bits.sv
// contador_bits: bit-pair index counter.
//   i_clk, i_reset_L : clock, async active-low reset
//   i_clr            : synchronous clear to 0 (has priority over i_en)
//   i_en             : increment by one
//   o_k / o_k_sig    : current index and current index + 1
//   o_term           : o_k == N
//   o_term_sig       : o_k + 1 == N (lets the caller register ultimo a cycle early)
module contador_bits
  import serializador_der_izq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = ancho_cnt(N)
) (
  input  logic          i_clk,
  input  logic          i_reset_L,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_k,
  output logic [CW-1:0] o_k_sig,
  output logic          o_term,
  output logic          o_term_sig
);

  // CW = clog2(N+1), so N always fits at counter width.
  localparam logic [CW-1:0] K_FIN = CW'(N);

  logic [CW-1:0] r_k;
  logic [CW-1:0] w_k_sig;

  assign w_k_sig = r_k + CW'(1);

  always_ff @(posedge i_clk or negedge i_reset_L) begin
    if (!i_reset_L)  r_k <= '0;
    else if (i_clr)  r_k <= '0;
    else if (i_en)   r_k <= w_k_sig;
  end

  assign o_k        = r_k;
  assign o_k_sig    = w_k_sig;
  assign o_term     = (r_k == K_FIN);
  assign o_term_sig = (w_k_sig == K_FIN);

endmodule

// File: rtl/serializador_der_izq.sv
// serializador_der_izq: feeds two N+1-bit words LSB first, one bit pair per
// clock, to the right-to-left comparison network and captures its result.
//   i_clk, i_reset_L         : clock, async active-low reset
//   i_inicio                 : start request, honoured only in IDLE
//   i_palabraA/B, i_x_inicial: parallel words and initial state
//   i_z_in                   : network result, valid during CAPTURA
//   o_ocupado                : load edge through capture cycle
//   o_a_s/o_b_s/o_bit_valido : current bit pair and its qualifier
//   o_primero/o_ultimo       : pair is bit 0 / bit N
//   o_x_p                    : latched initial state
//   o_resultado/o_listo      : held result, one-cycle completion pulse
module serializador_der_izq
  import serializador_der_izq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_L,
  input  logic         i_inicio,
  input  logic [N:0]   i_palabraA,
  input  logic [N:0]   i_palabraB,
  input  logic [N-1:0] i_x_inicial,
  input  logic         i_z_in,
  output logic         o_ocupado,
  output logic         o_a_s,
  output logic         o_b_s,
  output logic         o_bit_valido,
  output logic         o_primero,
  output logic         o_ultimo,
  output logic [N-1:0] o_x_p,
  output logic         o_resultado,
  output logic         o_listo
);

  localparam int CW = ancho_cnt(N);

  estado_t       r_estado;
  logic [N:0]    r_a, r_b;
  logic [CW-1:0] w_k, w_k_sig;
  logic          w_term, w_term_sig;
  logic          w_carga, w_avanza;

  assign w_carga  = (r_estado == IDLE) && i_inicio;
  assign w_avanza = (r_estado == DESPLAZA) && !w_term;

  contador_bits #(.N(N), .CW(CW)) u_cnt (
    .i_clk      (i_clk),
    .i_reset_L  (i_reset_L),
    .i_clr      (w_carga),
    .i_en       (w_avanza),
    .o_k        (w_k),
    .o_k_sig    (w_k_sig),
    .o_term     (w_term),
    .o_term_sig (w_term_sig)
  );

  // Outputs are registered, so each edge presents the pair for the index the
  // counter moves to on that same edge: bit 0 comes straight from the input
  // words at the load edge, later bits from the shadow copy at k+1.
  always_ff @(posedge i_clk or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_estado     <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      o_ocupado    <= 1'b0;
      o_a_s        <= 1'b0;
      o_b_s        <= 1'b0;
      o_bit_valido <= 1'b0;
      o_primero    <= 1'b0;
      o_ultimo     <= 1'b0;
      o_x_p        <= '0;
      o_resultado  <= 1'b0;
      o_listo      <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (i_inicio) begin
            r_a          <= i_palabraA;
            r_b          <= i_palabraB;
            o_x_p        <= i_x_inicial;
            o_a_s        <= i_palabraA[0];
            o_b_s        <= i_palabraB[0];
            o_bit_valido <= 1'b1;
            o_primero    <= 1'b1;
            o_ultimo     <= (N == 0);
            o_ocupado    <= 1'b1;
            r_estado     <= DESPLAZA;
          end
        end
        DESPLAZA: begin
          o_primero <= 1'b0;
          if (w_term) begin
            o_a_s        <= 1'b0;
            o_b_s        <= 1'b0;
            o_bit_valido <= 1'b0;
            o_ultimo     <= 1'b0;
            o_listo      <= 1'b1;
            r_estado     <= CAPTURA;
          end else begin
            o_a_s    <= r_a[w_k_sig];
            o_b_s    <= r_b[w_k_sig];
            o_ultimo <= w_term_sig;
          end
        end
        CAPTURA: begin
          o_resultado <= i_z_in;
          o_listo     <= 1'b0;
          o_ocupado   <= 1'b0;
          r_estado    <= IDLE;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^w_k;

endmodule

// File: tb/tb_serializador_der_izq.sv
module tb_serializador_der_izq;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ini = 1'b0;
  logic [N:0]   A = '0, B = '0;
  logic [N-1:0] X = '0;
  logic         z = 1'b0;

  logic         o_ocupado, o_a_s, o_b_s, o_bit_valido, o_primero, o_ultimo;
  logic [N-1:0] o_x_p;
  logic         o_resultado, o_listo;

  serializador_der_izq #(.N(N)) dut (
    .i_clk(clk), .i_reset_L(rst_n), .i_inicio(ini),
    .i_palabraA(A), .i_palabraB(B), .i_x_inicial(X), .i_z_in(z),
    .o_ocupado(o_ocupado), .o_a_s(o_a_s), .o_b_s(o_b_s),
    .o_bit_valido(o_bit_valido), .o_primero(o_primero), .o_ultimo(o_ultimo),
    .o_x_p(o_x_p), .o_resultado(o_resultado), .o_listo(o_listo)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  // Reference: a transaction accepted at edge t0 shows bit d after edge t0+d
  // (d=0..N), completes in cycle t0+N+1, and the result is z at edge t0+N+2.
  bit           have = 0;
  int           t0 = 0;
  logic [N:0]   mA = '0, mB = '0;
  logic [N-1:0] mxp = '0;
  logic         mres = 1'b0;
  int           listo_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int d;
    bit act, sh;
    logic [N:0] ta, tbb;
    d   = cyc - t0;
    act = have && d >= 0 && d <= N + 1;
    sh  = act && d <= N;
    ta  = sh ? (mA >> d) : '0;
    tbb = sh ? (mB >> d) : '0;
    chk("ocupado",    32'(o_ocupado),    32'(act));
    chk("bit_valido", 32'(o_bit_valido), 32'(sh));
    chk("a_s",        32'(o_a_s),        32'(ta[0]));
    chk("b_s",        32'(o_b_s),        32'(tbb[0]));
    chk("primero",    32'(o_primero),    32'(sh && d == 0));
    chk("ultimo",     32'(o_ultimo),     32'(sh && d == N));
    chk("listo",      32'(o_listo),      32'(act && d == N + 1));
    chk("x_p",        32'(o_x_p),        32'(mxp));
    chk("resultado",  32'(o_resultado),  32'(mres));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (have && cyc == t0 + N + 2) mres = z;
      if (ini && (!have || cyc - t0 >= N + 3)) begin
        have = 1; t0 = cyc; mA = A; mB = B; mxp = X;
      end
    end
    @(negedge clk);
    check_all();
    if (o_listo) listo_q.push_back(cyc);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    have = 0; mres = 1'b0; mxp = '0;
    #1 check_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    #1 rst_n = 1'b0;
    #2 check_all();
    step(); step();
    rst_n = 1'b1;
    step();

    // basic stream
    listo_q.delete();
    A = 5'b10110; B = 5'b10011; X = 4'b1010; ini = 1'b1;
    step(); ini = 1'b0;
    repeat (4) step();
    z = 1'b1;
    repeat (4) step();
    chk("basic_listo_cnt", 32'(listo_q.size()), 32'd1);
    chk("basic_resultado", 32'(o_resultado), 32'd1);

    // busy rejection
    listo_q.delete();
    z = 1'b0; ini = 1'b1;
    step(); ini = 1'b0;
    step(); step();
    ini = 1'b1; step(); ini = 1'b0;
    repeat (10) step();
    chk("busy_listo_cnt", 32'(listo_q.size()), 32'd1);

    // input isolation
    A = 5'b10110; X = 4'b1010; z = 1'b1; ini = 1'b1;
    step(); ini = 1'b0;
    A = 5'b01001; X = 4'b0001;
    repeat (8) step();
    chk("iso_x_p", 32'(o_x_p), 32'(4'b1010));

    // reset abort on the 3rd pair, then a fresh run
    listo_q.delete();
    A = 5'b10110; X = 4'b1010; ini = 1'b1;
    step(); ini = 1'b0;
    step(); step();
    async_reset();
    chk("abort_listo_cnt", 32'(listo_q.size()), 32'd0);
    ini = 1'b1; step(); ini = 1'b0;
    repeat (8) step();
    chk("fresh_listo_cnt", 32'(listo_q.size()), 32'd1);

    // back-to-back with inicio held high
    listo_q.delete();
    ini = 1'b1;
    repeat (20) step();
    ini = 1'b0;
    repeat (8) step();
    chk("b2b_listo_cnt", 32'(listo_q.size()), 32'd3);
    for (int i = 1; i < listo_q.size(); i++)
      chk("b2b_period", 32'(listo_q[i] - listo_q[i-1]), 32'd7);

    // result hold
    z = 1'b0; ini = 1'b1;
    step(); ini = 1'b0;
    repeat (16) step();
    chk("hold_res0", 32'(o_resultado), 32'd0);
    z = 1'b1; ini = 1'b1;
    step(); ini = 1'b0;
    repeat (7) step();

    // randomized traffic
    repeat (400) begin
      A   = (N+1)'($urandom);
      B   = (N+1)'($urandom);
      X   = N'($urandom);
      z   = 1'($urandom);
      ini = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 60) == 0) async_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
